// File: rtl/of_pkg.sv
// Shared definitions for the operand-fetch sequencer: state encoding, instruction
// field positions and immediate modifier codes.
package of_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD1  = 3'd1;
  localparam logic [2:0] ST_RD2  = 3'd2;
  localparam logic [2:0] ST_CAP2 = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RD1  = ST_RD1,
    RD2  = ST_RD2,
    CAP2 = ST_CAP2,
    HOLD = ST_HOLD
  } state_e;

  // Instruction field positions
  localparam int OPCI_LSB  = 26;
  localparam int OPCI_W    = 6;
  localparam int I_BIT     = 26;
  localparam int RD_LSB    = 22;
  localparam int RS1_LSB   = 18;
  localparam int RS2_LSB   = 14;
  localparam int IMM_FLD_W = 18;
  localparam int IMM_W     = 16;
  localparam int MOD_LSB   = 16;
  localparam int OFF_W     = 27;

  // Immediate modifier codes (imm[17:16])
  localparam logic [1:0] MOD_SEXT = 2'b00;
  localparam logic [1:0] MOD_ZEXT = 2'b01;
  localparam logic [1:0] MOD_HI   = 2'b10;
  localparam logic [1:0] MOD_RSVD = 2'b11;

  localparam int RA_IDX_DEF = 15;

endpackage

// File: rtl/of_imm_ext.sv
// Combinational immediate extension and branch-target computation for the
// instruction being accepted by the sequencer.
module of_imm_ext
  import of_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [IMM_FLD_W-1:0] imm,
  input  logic [OFF_W-1:0]     offset,
  input  logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      immx,
  output logic [XLEN-1:0]      branch_target
);

  function automatic logic [XLEN-1:0] ext_imm(input logic [1:0] mode,
                                              input logic signed [IMM_W-1:0] val);
    logic [XLEN-1:0] res;
    case (mode)
      MOD_ZEXT: res = {{(XLEN-IMM_W){1'b0}}, val};
      MOD_HI:   res = {val, {(XLEN-IMM_W){1'b0}}};
      // MOD_SEXT, and the reserved code behaves the same way
      default:  res = {{(XLEN-IMM_W){val[IMM_W-1]}}, val};
    endcase
    return res;
  endfunction

  logic signed [XLEN-1:0] off_sx;

  always_comb begin
    off_sx        = {{(XLEN-OFF_W){offset[OFF_W-1]}}, offset};
    immx          = ext_imm(imm[MOD_LSB +: 2], imm[IMM_W-1:0]);
    branch_target = pc + (off_sx <<< 2);
  end

endmodule

// File: rtl/of_sequencer.sv
// Operand-fetch sequencer: reads up to two operands through the shared regfile
// port (writeback has priority) and offers the bundle to execute via valid/ready.
module of_sequencer
  import of_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int RA_IDX = RA_IDX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [XLEN-1:0]  instr,
  input  logic [XLEN-1:0]  pc,
  input  logic             is_st,
  input  logic             is_ret,
  input  logic             wb_req,
  output logic             wb_gnt,
  output logic             rf_rd_en,
  output logic [AW-1:0]    rf_addr,
  input  logic [XLEN-1:0]  rf_rd_data,
  output logic             of_valid,
  input  logic             of_ready,
  output logic [OPCI_W-1:0] opcode_out,
  output logic [XLEN-1:0]  op1_out,
  output logic [XLEN-1:0]  op2_out,
  output logic [XLEN-1:0]  immx_out,
  output logic [XLEN-1:0]  branch_target_out
);

  localparam logic [AW-1:0] RA_ADDR = AW'(RA_IDX % NREG);

  state_e             state_q, state_d;
  logic               cap_q, cap_d;
  logic               of_valid_q, of_valid_d;
  logic [OPCI_W-1:0]  opcode_q, opcode_d;
  logic [XLEN-1:0]    op1_q, op1_d;
  logic [XLEN-1:0]    op2_q, op2_d;
  logic [XLEN-1:0]    immx_q, immx_d;
  logic [XLEN-1:0]    bt_q, bt_d;
  logic [AW-1:0]      addr1_q, addr1_d;
  logic [AW-1:0]      addr2_q, addr2_d;
  logic               need2_q, need2_d;

  logic               rdy_c;
  logic               rd_en_c;
  logic [AW-1:0]      addr_c;
  logic [XLEN-1:0]    immx_c;
  logic [XLEN-1:0]    bt_c;

  of_imm_ext #(
    .XLEN(XLEN)
  ) u_imm_ext (
    .imm          (instr[IMM_FLD_W-1:0]),
    .offset       (instr[OFF_W-1:0]),
    .pc           (pc),
    .immx         (immx_c),
    .branch_target(bt_c)
  );

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    of_valid_d = of_valid_q;
    opcode_d   = opcode_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    immx_d     = immx_q;
    bt_d       = bt_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    need2_d    = need2_q;
    rdy_c      = 1'b0;
    rd_en_c    = 1'b0;
    addr_c     = '0;

    // Reads are only issued while writeback is idle, so wb always wins the port.
    case (state_q)
      IDLE: rdy_c = 1'b1;
      RD1: begin
        if (!wb_req) begin
          rd_en_c = 1'b1;
          addr_c  = addr1_q;
          state_d = RD2;
        end
      end
      RD2: begin
        if (!cap_q) op1_d = rf_rd_data;
        if (!need2_q) begin
          op2_d      = '0;
          state_d    = HOLD;
          of_valid_d = 1'b1;
        end else if (wb_req) begin
          cap_d = 1'b1;
        end else begin
          rd_en_c = 1'b1;
          addr_c  = addr2_q;
          cap_d   = 1'b0;
          state_d = CAP2;
        end
      end
      CAP2: begin
        op2_d      = rf_rd_data;
        state_d    = HOLD;
        of_valid_d = 1'b1;
      end
      HOLD: begin
        if (of_ready) begin
          rdy_c      = 1'b1;
          state_d    = IDLE;
          of_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort discards any read data in flight and keeps the last operands.
    if (flush) begin
      rdy_c      = 1'b0;
      state_d    = IDLE;
      of_valid_d = 1'b0;
      cap_d      = 1'b0;
      op1_d      = op1_q;
      op2_d      = op2_q;
    end else if (rdy_c && instr_valid) begin
      state_d  = RD1;
      cap_d    = 1'b0;
      opcode_d = instr[OPCI_LSB +: OPCI_W];
      immx_d   = immx_c;
      bt_d     = bt_c;
      addr1_d  = is_ret ? RA_ADDR : instr[RS1_LSB +: AW];
      addr2_d  = is_st ? instr[RD_LSB +: AW] : instr[RS2_LSB +: AW];
      need2_d  = !instr[I_BIT] || is_st;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_q      <= 1'b0;
      of_valid_q <= 1'b0;
      opcode_q   <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      immx_q     <= '0;
      bt_q       <= '0;
      addr1_q    <= '0;
      addr2_q    <= '0;
      need2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      of_valid_q <= of_valid_d;
      opcode_q   <= opcode_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      immx_q     <= immx_d;
      bt_q       <= bt_d;
      addr1_q    <= addr1_d;
      addr2_q    <= addr2_d;
      need2_q    <= need2_d;
    end
  end

  assign instr_ready       = rdy_c;
  assign wb_gnt            = wb_req;
  assign rf_rd_en          = rd_en_c;
  assign rf_addr           = addr_c;
  assign of_valid          = of_valid_q;
  assign opcode_out        = opcode_q;
  assign op1_out           = op1_q;
  assign op2_out           = op2_q;
  assign immx_out          = immx_q;
  assign branch_target_out = bt_q;

endmodule

// File: tb/tb_of_sequencer.sv
// Directed bench for of_sequencer with a spec-level bundle model and a per-cycle
// monitor comparing port arbitration, read addresses, latency and bundle contents.
module tb_of_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        instr_valid = 1'b0;
  logic        is_st = 1'b0;
  logic        is_ret = 1'b0;
  logic        wb_req = 1'b0;
  logic        of_ready = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rf_rd_data = '0;
  logic        instr_ready, wb_gnt, rf_rd_en, of_valid;
  logic [3:0]  rf_addr;
  logic [5:0]  opcode_out;
  logic [31:0] op1_out, op2_out, immx_out, branch_target_out;

  of_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .is_st(is_st), .is_ret(is_ret),
    .wb_req(wb_req), .wb_gnt(wb_gnt),
    .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_rd_data(rf_rd_data),
    .of_valid(of_valid), .of_ready(of_ready),
    .opcode_out(opcode_out), .op1_out(op1_out), .op2_out(op2_out),
    .immx_out(immx_out), .branch_target_out(branch_target_out)
  );

  always #5 clk = ~clk;

  // Regfile with synchronous read; junk appears when no read was issued
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= mem[rf_addr];
    else          rf_rd_data <= 32'hBAD0_BAD0;
  end

  int errors = 0;
  int checks = 0;
  bit mon_en = 0;
  bit seen = 0;
  bit expect_bundle = 0;
  int lat_cnt = -1;
  int exp_lat;
  bit exp_need2;
  logic [5:0]  exp_opc;
  logic [31:0] exp_op1, exp_op2, exp_immx, exp_bt;
  logic [3:0]  exp_addrs[$];
  logic [3:0]  got_addrs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic i, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [17:0] lo);
    return {opc, i, rd, rs1, lo};
  endfunction

  // What the bundle must contain, straight from the instruction format rules
  task automatic model(input logic [31:0] ins, input logic [31:0] p, input logic st, input logic ret);
    logic [3:0] a1, a2;
    a1 = ret ? 4'd15 : ins[21:18];
    a2 = st ? ins[25:22] : ins[17:14];
    exp_need2 = !ins[26] || st;
    exp_opc = ins[31:26];
    exp_op1 = mem[a1];
    exp_op2 = exp_need2 ? mem[a2] : 32'h0;
    case (ins[17:16])
      2'b01:   exp_immx = {16'h0, ins[15:0]};
      2'b10:   exp_immx = {ins[15:0], 16'h0};
      default: exp_immx = {{16{ins[15]}}, ins[15:0]};
    endcase
    exp_bt = p + {{3{ins[26]}}, ins[26:0], 2'b00};
    exp_lat = exp_need2 ? 4 : 3;
    exp_addrs.delete();
    exp_addrs.push_back(a1);
    if (exp_need2) exp_addrs.push_back(a2);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mon_en) begin
        chk("wb_gnt", 32'(wb_gnt), 32'(wb_req));
        if (rf_rd_en) begin
          chk("read_during_wb", 32'(wb_req), 32'h0);
          got_addrs.push_back(rf_addr);
        end
        if (lat_cnt >= 0) lat_cnt++;
        if (instr_valid && instr_ready) lat_cnt = 0;
        if (of_valid) begin
          if (!expect_bundle) chk("spurious_of_valid", 32'(of_valid), 32'(expect_bundle));
          else begin
            if (!seen) begin
              seen = 1;
              chk("latency", 32'(lat_cnt), 32'(exp_lat));
              chk("num_reads", 32'(got_addrs.size()), 32'(exp_addrs.size()));
              foreach (exp_addrs[i])
                if (i < got_addrs.size()) chk("rf_addr", 32'(got_addrs[i]), 32'(exp_addrs[i]));
            end
            chk("opcode_out", 32'(opcode_out), 32'(exp_opc));
            chk("op1_out", op1_out, exp_op1);
            chk("op2_out", op2_out, exp_op2);
            chk("immx_out", immx_out, exp_immx);
            chk("branch_target_out", branch_target_out, exp_bt);
            if (!of_ready) chk("instr_ready_in_hold", 32'(instr_ready), 32'h0);
            else expect_bundle = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] p, input logic st, input logic ret,
                       input int stall_at, input int stall, input int bp);
    model(ins, p, st, ret);
    if (stall > 0 && (stall_at == 0 || (stall_at == 1 && exp_need2))) exp_lat += stall;
    @(posedge clk); #1;
    got_addrs.delete();
    seen = 0; expect_bundle = 1; lat_cnt = -1;
    instr = ins; pc = p; is_st = st; is_ret = ret; instr_valid = 1;
    of_ready = (bp == 0);
    @(posedge clk); #1;
    instr_valid = 0; instr = 32'hFFFF_FFFF; pc = 32'hFFFF_FFFF; is_st = 0; is_ret = 0;
    if (stall > 0) begin
      if (stall_at > 0) begin
        repeat (stall_at) @(posedge clk);
        #1;
      end
      wb_req = 1;
      repeat (stall) @(posedge clk);
      #1 wb_req = 0;
    end
    for (int i = 0; i < 20 && !seen; i++) @(posedge clk);
    chk("bundle_seen", 32'(seen), 32'h1);
    if (bp > 0) begin
      repeat (bp - 1) @(posedge clk);
      #1 of_ready = 1;
      @(posedge clk);
    end
    #1 of_ready = 1;
    @(negedge clk);
    chk("idle_instr_ready", 32'(instr_ready), 32'h1);
    chk("of_valid_drops", 32'(of_valid), 32'h0);
  endtask

  logic [31:0] add_i;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h11;
    mem[2] = 32'd5;
    mem[3] = 32'd7;
    mem[15] = 32'h100;
    add_i = mk(5'h01, 1'b0, 4'd1, 4'd2, {4'd3, 14'd0});

    // Reset state
    #2 wb_req = 1;
    #1 chk("rst_wb_gnt_hi", 32'(wb_gnt), 32'h1);
    wb_req = 0;
    #1 chk("rst_wb_gnt_lo", 32'(wb_gnt), 32'h0);
    chk("rst_instr_ready", 32'(instr_ready), 32'h1);
    chk("rst_of_valid", 32'(of_valid), 32'h0);
    chk("rst_rf_rd_en", 32'(rf_rd_en), 32'h0);
    chk("rst_rf_addr", 32'(rf_addr), 32'h0);
    chk("rst_opcode", 32'(opcode_out), 32'h0);
    chk("rst_op1", op1_out, 32'h0);
    chk("rst_op2", op2_out, 32'h0);
    chk("rst_immx", immx_out, 32'h0);
    chk("rst_bt", branch_target_out, 32'h0);
    @(negedge clk); rst = 0; mon_en = 1;

    // ADD r1,r2,r3
    issue(add_i, 32'h0, 0, 0, 0, 0, 0);
    chk("pin_add_op1", exp_op1, 32'd5);
    chk("pin_add_op2", exp_op2, 32'd7);
    chk("pin_add_lat", 32'(exp_lat), 32'd4);
    chk("pin_add_addr0", 32'(exp_addrs[0]), 32'd2);
    chk("pin_add_addr1", 32'(exp_addrs[1]), 32'd3);

    // ret
    issue(mk(5'h1E, 1'b1, 4'd0, 4'd0, 18'd0), 32'h80, 0, 1, 0, 0, 0);
    chk("pin_ret_op1", exp_op1, 32'h100);
    chk("pin_ret_addr0", 32'(exp_addrs[0]), 32'd15);

    // st r4,[r5+8]
    issue(mk(5'h05, 1'b1, 4'd4, 4'd5, 18'd8), 32'h10, 1, 0, 0, 0, 0);
    chk("pin_st_op2", exp_op2, 32'h44);
    chk("pin_st_immx", exp_immx, 32'd8);
    chk("pin_st_addr1", 32'(exp_addrs[1]), 32'd4);

    // mov with each immediate modifier
    issue(mk(5'h02, 1'b1, 4'd1, 4'd0, {2'b00, 16'hFFFF}), 32'h20, 0, 0, 0, 0, 0);
    chk("pin_mov_immx", exp_immx, 32'hFFFF_FFFF);
    chk("pin_mov_op2", exp_op2, 32'h0);
    chk("pin_mov_lat", 32'(exp_lat), 32'd3);
    issue(mk(5'h02, 1'b1, 4'd1, 4'd0, {2'b10, 16'h1234}), 32'h24, 0, 0, 0, 0, 0);
    chk("pin_hi_immx", exp_immx, 32'h1234_0000);
    issue(mk(5'h02, 1'b1, 4'd1, 4'd0, {2'b01, 16'h8001}), 32'h28, 0, 0, 0, 0, 0);
    chk("pin_zext_immx", exp_immx, 32'h0000_8001);
    issue(mk(5'h02, 1'b1, 4'd1, 4'd0, {2'b11, 16'h8001}), 32'h2C, 0, 0, 0, 0, 0);
    chk("pin_rsvd_immx", exp_immx, 32'hFFFF_8001);

    // Writeback stalls in RD1 and in RD2
    issue(add_i, 32'h0, 0, 0, 0, 2, 0);
    chk("pin_rd1_stall_lat", 32'(exp_lat), 32'd6);
    issue(add_i, 32'h0, 0, 0, 1, 2, 0);
    chk("pin_rd2_stall_lat", 32'(exp_lat), 32'd6);

    // Back-pressure
    issue(add_i, 32'h0, 0, 0, 0, 0, 3);

    // Branch target
    issue({5'h10, 27'h7FF_FFFC}, 32'h40, 0, 0, 0, 0, 0);
    chk("pin_branch_target", exp_bt, 32'h30);

    // flush beats instr_valid in IDLE
    @(posedge clk); #1;
    expect_bundle = 0;
    instr = add_i; instr_valid = 1; flush = 1;
    @(negedge clk) chk("flush_idle_no_accept", 32'(instr_ready), 32'h0);
    @(posedge clk); #1 instr_valid = 0; flush = 0;

    // flush in CAP2
    @(posedge clk); #1;
    got_addrs.delete();
    instr = add_i; instr_valid = 1;
    @(posedge clk); #1 instr_valid = 0;
    @(posedge clk);
    @(posedge clk); #1 flush = 1;
    @(negedge clk) chk("flush_cap2_ready", 32'(instr_ready), 32'h0);
    @(posedge clk); #1 flush = 0;
    @(negedge clk) chk("flush_to_idle", 32'(instr_ready), 32'h1);
    repeat (6) @(posedge clk);
    issue(add_i, 32'h4, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-operation
    @(posedge clk); #1;
    expect_bundle = 0;
    instr = add_i; instr_valid = 1;
    @(posedge clk); #1 instr_valid = 0;
    @(posedge clk); #2 rst = 1;
    #1;
    chk("arst_of_valid", 32'(of_valid), 32'h0);
    chk("arst_instr_ready", 32'(instr_ready), 32'h1);
    chk("arst_opcode", 32'(opcode_out), 32'h0);
    chk("arst_op1", op1_out, 32'h0);
    chk("arst_rf_rd_en", 32'(rf_rd_en), 32'h0);
    @(negedge clk) rst = 0;
    repeat (6) @(posedge clk);
    issue(mk(5'h05, 1'b1, 4'd4, 4'd5, 18'd8), 32'h10, 1, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
